// File: rtl/alarm_scheduler.sv
// Alarm scheduler: NUM_SLOTS programmable hh:mm alarms driving one ringer with snooze/stop.
// Latency: one clk_1s edge from the :00 sample (or a snooze/stop/disarm request) to the outputs.
// Backpressure: none; snooze/stop are level-sampled every second, and requests that do not apply are dropped.
module alarm_scheduler #(
  parameter int NUM_SLOTS  = 4,
  parameter int SNOOZE_S   = 300,
  parameter int RING_S     = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [2:0] cur_m1,
  input  logic [3:0] cur_m0,
  input  logic [2:0] cur_s1,
  input  logic [3:0] cur_s0,
  input  logic       prog_en,
  input  logic [1:0] prog_slot,
  input  logic [1:0] prog_h1,
  input  logic [3:0] prog_h0,
  input  logic [2:0] prog_m1,
  input  logic [3:0] prog_m0,
  input  logic       prog_arm,
  input  logic       snooze,
  input  logic       stop,
  output logic       alarm,
  output logic [1:0] active_slot,
  output logic [1:0] state,
  output logic [2:0] snoozes_left
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZED = 2'b10
  } state_t;

  localparam logic [2:0] NUM_SLOTS_U = 3'(NUM_SLOTS);
  localparam logic [7:0] RING_T      = 8'(RING_S);
  localparam logic [9:0] SNOOZE_T    = 10'(SNOOZE_S);
  localparam logic [2:0] LEFT_INIT   = 3'(MAX_SNOOZE);

  logic [1:0] slot_h1 [NUM_SLOTS];
  logic [3:0] slot_h0 [NUM_SLOTS];
  logic [2:0] slot_m1 [NUM_SLOTS];
  logic [3:0] slot_m0 [NUM_SLOTS];
  logic       slot_arm[NUM_SLOTS];

  state_t     state_q, state_d;
  logic [7:0] ring_q, ring_d;
  logic [9:0] snz_q, snz_d;
  logic [2:0] left_q, left_d;
  logic [1:0] slot_q, slot_d;
  logic       alarm_q, alarm_d;
  logic       lock_q, lock_d;

  logic       prog_ok;
  logic       sec_zero;
  logic       hit;
  logic [1:0] winner;
  logic       kill;

  assign prog_ok  = ({1'b0, prog_slot} < NUM_SLOTS_U);
  assign sec_zero = (cur_s1 == 3'd0) && (cur_s0 == 4'd0);
  // Disarming the slot that owns the event cancels it; re-arming it does not.
  assign kill     = prog_en && prog_ok && !prog_arm && (prog_slot == slot_q);

  // Slot table: write the addressed slot, out-of-range indices are dropped.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_h1[i]  <= '0;
        slot_h0[i]  <= '0;
        slot_m1[i]  <= '0;
        slot_m0[i]  <= '0;
        slot_arm[i] <= 1'b0;
      end
    end else if (prog_en && prog_ok) begin
      slot_h1[prog_slot]  <= prog_h1;
      slot_h0[prog_slot]  <= prog_h0;
      slot_m1[prog_slot]  <= prog_m1;
      slot_m0[prog_slot]  <= prog_m0;
      slot_arm[prog_slot] <= prog_arm;
    end
  end

  // Match detect at :00; scanning downward leaves the lowest matching index as winner.
  always_comb begin
    hit    = 1'b0;
    winner = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_arm[i] && slot_h1[i] == cur_h1 && slot_h0[i] == cur_h0 &&
          slot_m1[i] == cur_m1 && slot_m0[i] == cur_m0) begin
        hit    = 1'b1;
        winner = 2'(i);
      end
    end
    // The lock keeps an event released during its own :00 second from re-firing.
    if (!sec_zero || lock_q) hit = 1'b0;
  end

  // Next-state and output logic; stop and disarm outrank snooze, snooze outranks expiry.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    left_d  = left_q;
    slot_d  = slot_q;
    alarm_d = alarm_q;
    lock_d  = sec_zero ? lock_q : 1'b0;
    case (state_q)
      IDLE: begin
        alarm_d = 1'b0;
        if (hit) begin
          state_d = RINGING;
          alarm_d = 1'b1;
          slot_d  = winner;
          ring_d  = RING_T;
          snz_d   = '0;
          left_d  = LEFT_INIT;
          lock_d  = 1'b1;
        end
      end
      RINGING: begin
        if (stop || kill) begin
          state_d = IDLE;
          alarm_d = 1'b0;
          ring_d  = '0;
        end else if (snooze && left_q != 3'd0) begin
          state_d = SNOOZED;
          alarm_d = 1'b0;
          ring_d  = '0;
          snz_d   = SNOOZE_T;
          left_d  = left_q - 3'd1;
        end else if (ring_q <= 8'd1) begin
          state_d = IDLE;
          alarm_d = 1'b0;
          ring_d  = '0;
        end else begin
          ring_d  = ring_q - 8'd1;
        end
      end
      SNOOZED: begin
        if (stop || kill) begin
          state_d = IDLE;
          alarm_d = 1'b0;
          snz_d   = '0;
        end else if (snz_q <= 10'd1) begin
          state_d = RINGING;
          alarm_d = 1'b1;
          snz_d   = '0;
          ring_d  = RING_T;
        end else begin
          snz_d   = snz_q - 10'd1;
        end
      end
      default: begin
        state_d = IDLE;
        alarm_d = 1'b0;
      end
    endcase
  end

  // Event state registers.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ring_q  <= '0;
      snz_q   <= '0;
      left_q  <= '0;
      slot_q  <= '0;
      alarm_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      left_q  <= left_d;
      slot_q  <= slot_d;
      alarm_q <= alarm_d;
      lock_q  <= lock_d;
    end
  end

  assign alarm        = alarm_q;
  assign active_slot  = slot_q;
  assign state        = state_q;
  assign snoozes_left = left_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: directed scenarios followed by random traffic.
// Every edge is predicted by a per-second behavioural model of the alarm rules.
// Outputs are sampled 1 time unit after each rising clk_1s edge.
module tb_alarm_scheduler;
  localparam int SNZ  = 5;
  localparam int RNG  = 8;
  localparam int MAXS = 3;

  logic       clk_1s = 1'b0;
  logic       reset;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0;
  logic [2:0] cur_m1;
  logic [3:0] cur_m0;
  logic [2:0] cur_s1;
  logic [3:0] cur_s0;
  logic       prog_en;
  logic [1:0] prog_slot;
  logic [1:0] prog_h1;
  logic [3:0] prog_h0;
  logic [2:0] prog_m1;
  logic [3:0] prog_m0;
  logic       prog_arm;
  logic       snooze;
  logic       stop;
  logic       alarm;
  logic [1:0] active_slot;
  logic [1:0] state;
  logic [2:0] snoozes_left;

  alarm_scheduler #(.NUM_SLOTS(4), .SNOOZE_S(SNZ), .RING_S(RNG), .MAX_SNOOZE(MAXS)) dut (
    .clk_1s(clk_1s), .reset(reset),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .cur_s1(cur_s1), .cur_s0(cur_s0),
    .prog_en(prog_en), .prog_slot(prog_slot),
    .prog_h1(prog_h1), .prog_h0(prog_h0), .prog_m1(prog_m1), .prog_m0(prog_m0),
    .prog_arm(prog_arm), .snooze(snooze), .stop(stop),
    .alarm(alarm), .active_slot(active_slot), .state(state), .snoozes_left(snoozes_left)
  );

  always #5 clk_1s = ~clk_1s;

  int n_vec = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1 ringing, 2 snoozed; remain = seconds left in current phase.
  int m_mode, m_slot, m_left, m_remain;
  bit m_lock;
  bit s_arm[4];
  int s_h[4], s_m[4];
  int c_h, c_m, c_s, p_h, p_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    c_h = h; c_m = m; c_s = s;
    cur_h1 = 2'(h / 10); cur_h0 = 4'(h % 10);
    cur_m1 = 3'(m / 10); cur_m0 = 4'(m % 10);
    cur_s1 = 3'(s / 10); cur_s0 = 4'(s % 10);
  endtask

  task automatic prog(input int slot, input int h, input int m, input bit arm);
    prog_en = 1'b1; prog_slot = 2'(slot); prog_arm = arm;
    p_h = h; p_m = m;
    prog_h1 = 2'(h / 10); prog_h0 = 4'(h % 10);
    prog_m1 = 3'(m / 10); prog_m0 = 4'(m % 10);
  endtask

  task automatic model_reset();
    m_mode = 0; m_slot = 0; m_left = 0; m_remain = 0; m_lock = 0;
    for (int i = 0; i < 4; i++) begin s_arm[i] = 0; s_h[i] = 0; s_m[i] = 0; end
  endtask

  task automatic model_step();
    int  w;
    bit  kill, fired;
    w = -1;
    if (!m_lock && c_s == 0)
      for (int i = 3; i >= 0; i--)
        if (s_arm[i] && s_h[i] == c_h && s_m[i] == c_m) w = i;
    kill  = prog_en && !prog_arm && int'(prog_slot) == m_slot;
    fired = (m_mode == 0) && (w >= 0);
    if (m_mode == 0) begin
      if (fired) begin m_mode = 1; m_slot = w; m_left = MAXS; m_remain = RNG; end
    end else if (stop || kill) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (snooze && m_left > 0) begin m_mode = 2; m_left--; m_remain = SNZ; end
      else begin m_remain--; if (m_remain <= 0) m_mode = 0; end
    end else begin
      m_remain--;
      if (m_remain <= 0) begin m_mode = 1; m_remain = RNG; end
    end
    if (fired) m_lock = 1;
    else if (c_s != 0) m_lock = 0;
    if (prog_en) begin
      s_arm[prog_slot] = prog_arm; s_h[prog_slot] = p_h; s_m[prog_slot] = p_m;
    end
  endtask

  // One second: predict, clock, compare, drop one-shot requests.
  task automatic step();
    model_step();
    @(posedge clk_1s);
    #1;
    check("alarm", alarm, (m_mode == 1) ? 1 : 0);
    check("state", state, m_mode);
    check("active_slot", active_slot, m_slot);
    check("snoozes_left", snoozes_left, m_left);
    prog_en = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  task automatic tick(input int h, input int m, input int s);
    set_time(h, m, s);
    step();
  endtask

  initial begin
    int sec;
    reset = 1'b1; prog_en = 0; prog_slot = 0; prog_arm = 0;
    prog_h1 = 0; prog_h0 = 0; prog_m1 = 0; prog_m0 = 0;
    snooze = 0; stop = 0; p_h = 0; p_m = 0;
    set_time(0, 0, 1);
    model_reset();
    #1;
    check("rst_alarm", alarm, 0);
    check("rst_state", state, 0);
    check("rst_slot", active_slot, 0);
    check("rst_left", snoozes_left, 0);
    @(posedge clk_1s); #1; reset = 1'b0;

    // Slot 1 at 07:30 fires on the :00 edge.
    prog(1, 7, 30, 1); tick(0, 0, 5);
    tick(7, 29, 59);
    tick(7, 30, 0);
    check("r036_alarm", alarm, 1);
    check("r036_slot", active_slot, 1);
    check("r036_state", state, 1);
    tick(7, 30, 0);
    stop = 1; tick(7, 30, 0);
    tick(7, 30, 0);
    check("no_refire_state", state, 0);

    // Slots 0 and 2 tie at 06:00; lowest wins. Then snooze and its expiry.
    prog(0, 6, 0, 1); tick(7, 30, 1);
    prog(2, 6, 0, 1); tick(7, 30, 2);
    tick(5, 59, 59);
    tick(6, 0, 0);
    check("tie_slot", active_slot, 0);
    snooze = 1; tick(6, 0, 1);
    check("snz_alarm", alarm, 0);
    check("snz_left", snoozes_left, 2);
    for (int k = 2; k <= 5; k++) tick(6, 0, k);
    check("snz_wait_state", state, 2);
    tick(6, 0, 6);
    check("snz_end_alarm", alarm, 1);
    check("snz_end_state", state, 1);

    // stop and snooze together: stop wins, snoozes_left unchanged.
    stop = 1; snooze = 1; tick(6, 0, 7);
    check("both_state", state, 0);
    check("both_alarm", alarm, 0);
    check("both_left", snoozes_left, 2);

    // Exhaust all snoozes, then a further snooze is ignored and the ring times out.
    prog(0, 6, 1, 1); tick(6, 0, 8);
    tick(6, 1, 0);
    sec = 1;
    for (int n = 0; n < MAXS; n++) begin
      snooze = 1; tick(6, 1, sec); sec++;
      for (int k = 0; k < SNZ; k++) begin tick(6, 1, sec); sec++; end
    end
    check("exh_left", snoozes_left, 0);
    snooze = 1; tick(6, 1, sec); sec++;
    check("exh_ign_alarm", alarm, 1);
    for (int k = 2; k <= RNG; k++) begin
      tick(6, 1, sec); sec++;
      if (k == RNG - 1) check("exh_last_alarm", alarm, 1);
    end
    check("exh_timeout_state", state, 0);

    // Snoozed on slot 3, disarming slot 3 ends the event.
    prog(3, 12, 0, 1); tick(6, 2, 1);
    tick(12, 0, 0);
    check("s3_slot", active_slot, 3);
    snooze = 1; tick(12, 0, 1);
    prog(3, 12, 0, 0); tick(12, 0, 2);
    check("disarm_state", state, 0);

    // Asynchronous reset mid-ring clears outputs without a clock edge.
    prog(3, 12, 1, 1); tick(12, 0, 3);
    tick(12, 1, 0);
    tick(12, 1, 1);
    check("pre_rst_alarm", alarm, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_alarm", alarm, 0);
    check("arst_state", state, 0);
    check("arst_slot", active_slot, 0);
    check("arst_left", snoozes_left, 0);
    model_reset();
    @(posedge clk_1s); #1; reset = 1'b0;
    tick(12, 1, 2);

    // Random traffic over a small set of times so matches happen often.
    for (int n = 0; n < 400; n++) begin
      int hh, mm, ss;
      hh = ($urandom_range(0, 1) == 0) ? 6 : 12;
      mm = $urandom_range(0, 1);
      ss = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 59);
      if ($urandom_range(0, 3) == 0)
        prog($urandom_range(0, 3), ($urandom_range(0, 1) == 0) ? 6 : 12,
             $urandom_range(0, 1), $urandom_range(0, 2) != 0);
      snooze = ($urandom_range(0, 7) == 0);
      stop   = ($urandom_range(0, 15) == 0);
      tick(hh, mm, ss);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 Parameter: NUM_SLOTS, 4, number of alarm slots (2..4; slot index 2 bits).
REQ-002 Parameter: SNOOZE_S, 300, snooze length in seconds (1..1023).
REQ-003 Parameter: RING_S, 60, maximum continuous ring time in seconds (1..255).
REQ-004 Parameter: MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7).
REQ-005 clk_1s  in  1  one-second clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 cur_h1/cur_h0/cur_m1/cur_m0/cur_s1/cur_s0  in  2/4/3/4/3/4  current time, BCD digits.
REQ-008 prog_en  in  1  write the slot selected by prog_slot this cycle.
REQ-009 prog_slot  in  2  slot index to write.
REQ-010 prog_h1/prog_h0/prog_m1/prog_m0  in  2/4/3/4  slot alarm time, BCD.
REQ-011 prog_arm  in  1  slot armed bit written with the time.
REQ-012 snooze  in  1  snooze request, level sampled per clk_1s.
REQ-013 stop  in  1  stop request, level sampled per clk_1s.
REQ-014 alarm  out  1  ringer drive, registered.
REQ-015 active_slot  out  2  slot owning the current event.
REQ-016 state  out  2  00 IDLE, 01 RINGING, 10 SNOOZED.
REQ-017 snoozes_left  out  3  remaining snoozes for the current event.

Function
REQ-018 Each slot SHALL hold hh:mm (BCD) plus armed bit; prog_en writes slot prog_slot at the clock edge; prog_slot >= NUM_SLOTS SHALL be ignored.
REQ-019 A slot matches when armed, its hh:mm equals cur hh:mm, and cur_s1 = 0 and cur_s0 = 0.
REQ-020 Among simultaneous matches, the lowest slot index SHALL win.
REQ-021 IDLE -> RINGING on a match: alarm = 1, active_slot = winner, ring timer = RING_S, snoozes_left = MAX_SNOOZE, all at the same edge as the :00 sample (one-edge latency).
REQ-022 RINGING: stop -> IDLE, alarm = 0.
REQ-023 RINGING: snooze with snoozes_left > 0 -> SNOOZED, alarm = 0, snooze timer = SNOOZE_S, snoozes_left decrements.
REQ-024 RINGING: snooze with snoozes_left = 0 SHALL be ignored.
REQ-025 RINGING: ring timer decrements each edge; on reaching 0 (RING_S edges after entry) -> IDLE, alarm = 0.
REQ-026 SNOOZED: snooze timer decrements each edge; on reaching 0 -> RINGING, alarm = 1, ring timer reloaded to RING_S.
REQ-027 SNOOZED: stop -> IDLE; snooze SHALL be ignored.
REQ-028 stop and snooze in the same cycle: stop wins.
REQ-029 Matches in RINGING or SNOOZED SHALL be ignored (no preemption, no queueing).
REQ-030 prog_en writing active_slot with prog_arm = 0 while not IDLE -> IDLE, alarm = 0, same edge.
REQ-031 Reprogramming a slot with prog_arm = 1 SHALL NOT disturb an event in progress.
REQ-032 Timers SHALL be wide enough for their parameter maximum; they SHALL saturate at 0, never wrap.
REQ-033 A slot matched and released to IDLE within the same minute SHALL NOT re-fire until the next :00 match.

Reset
REQ-034 reset SHALL asynchronously force state = IDLE, alarm = 0, active_slot = 0, snoozes_left = 0, timers = 0, all slots disarmed with time 00:00.
REQ-035 reset asserted mid-RINGING or mid-SNOOZED SHALL abort the event with no further alarm until a new match after release.

Verification
REQ-036 Program slot 1 = 07:30 armed; drive 07:29:59 -> 07:30:00 -> alarm = 1, active_slot = 1, state = 01 at that edge.
REQ-037 Slots 0 and 2 both 06:00 armed; at 06:00:00 -> active_slot = 0.
REQ-038 Ringing, SNOOZE_S = 5: snooze one cycle -> alarm = 0, snoozes_left = 2; 5 edges later alarm = 1, state = 01.
REQ-039 MAX_SNOOZE = 1: snooze, wait out, snooze again -> second snooze ignored; alarm stays 1 until RING_S edges elapse, then state = 00.
REQ-040 Ringing, stop and snooze together -> state = 00, alarm = 0, snoozes_left unchanged.
REQ-041 Snoozed on slot 3, prog_en slot 3 prog_arm = 0 -> state = 00; assert reset mid-RINGING -> all outputs 0 immediately.
